// File: rtl/zrb_uart_rx_os.sv
// zrb_uart_rx_os: oversampling UART receiver.
// Contains a fractional baud-tick generator, 2-of-3 majority sampling at mid-bit,
// a configurable frame format and a valid/ready output register with error flags.
module zrb_uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned INC   = OVERSAMPLE * BAUD;
  localparam int unsigned ACC_W = $clog2(CLK_FREQ + INC) + 1;
  localparam int unsigned SC_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W  = $clog2(DATA_BITS);

  localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(INC);
  localparam logic [ACC_W-1:0] ACC_MOD = ACC_W'(CLK_FREQ);

  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
  localparam logic [SC_W-1:0] SC_LO   = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] SC_HI   = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);

  localparam logic [BC_W-1:0] BC_ONE       = BC_W'(1);
  localparam logic [BC_W-1:0] BC_LAST_DATA = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] BC_LAST_STOP = BC_W'(STOP_BITS - 1);

  if (INC > CLK_FREQ) begin : g_inc_check
    $error("zrb_uart_rx_os: OVERSAMPLE*BAUD must not exceed CLK_FREQ");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [1:0] r_sync;
  logic       w_rxs;

  // Two-flop synchroniser for the asynchronous rx pin, idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rxs = r_sync[1];

  // ---------------------------------------------------------------------------
  // Fractional tick generator
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_sum;
  logic             r_tick;

  assign w_acc_sum = r_acc + ACC_INC;

  // Phase accumulator: one-clock tick each time the sum crosses CLK_FREQ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (w_acc_sum >= ACC_MOD) begin
      r_acc  <= w_acc_sum - ACC_MOD;
      r_tick <= 1'b1;
    end else begin
      r_acc  <= w_acc_sum;
      r_tick <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic [SC_W-1:0]      r_scnt;
  logic [SC_W-1:0]      w_scnt_nxt;
  logic [BC_W-1:0]      r_bcnt;
  logic [BC_W-1:0]      w_bcnt_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_ferr_acc;
  logic [1:0]           r_vote;
  logic                 r_prev_rxs;

  logic                 w_vote_pt;
  logic                 w_bit_end;
  logic                 w_maj;
  logic                 w_shift_en;
  logic                 w_par_ld;
  logic                 w_ferr_clr;
  logic                 w_ferr_set;
  logic                 w_done;
  logic                 w_par_xor;
  logic                 w_par_err;

  // The two earlier samples sit in r_vote; the third is the live synchronised bit.
  assign w_maj = (r_vote[1] & r_vote[0]) | (r_vote[1] & w_rxs) | (r_vote[0] & w_rxs);

  assign w_vote_pt = r_tick && (r_scnt == SC_HI);
  assign w_bit_end = r_tick && (r_scnt == SC_LAST);

  assign w_par_xor = (^r_shift) ^ r_par_bit;
  assign w_par_err = (PARITY == 1) ? ~w_par_xor :
                     (PARITY == 2) ?  w_par_xor : 1'b0;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and datapath strobes; counters only move on ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_bcnt_nxt  = r_bcnt;
    w_shift_en  = 1'b0;
    w_par_ld    = 1'b0;
    w_ferr_clr  = 1'b0;
    w_ferr_set  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Falling edge seen on a tick; this tick is sample 0 of the start bit.
        if (r_tick && !w_rxs && r_prev_rxs) begin
          w_state_nxt = S_START;
          w_scnt_nxt  = SC_ONE;
          w_ferr_clr  = 1'b1;
        end
      end
      S_START: begin
        if (r_tick) begin
          if (w_vote_pt && w_maj) begin
            w_state_nxt = S_IDLE;
            w_scnt_nxt  = '0;
          end else if (w_bit_end) begin
            w_state_nxt = S_DATA;
            w_scnt_nxt  = '0;
            w_bcnt_nxt  = '0;
          end else begin
            w_scnt_nxt  = r_scnt + SC_ONE;
          end
        end
      end
      S_DATA: begin
        if (r_tick) begin
          w_shift_en = w_vote_pt;
          if (w_bit_end) begin
            w_scnt_nxt = '0;
            if (r_bcnt == BC_LAST_DATA) begin
              w_bcnt_nxt  = '0;
              w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              w_bcnt_nxt  = r_bcnt + BC_ONE;
            end
          end else begin
            w_scnt_nxt = r_scnt + SC_ONE;
          end
        end
      end
      S_PARITY: begin
        if (r_tick) begin
          w_par_ld = w_vote_pt;
          if (w_bit_end) begin
            w_scnt_nxt  = '0;
            w_bcnt_nxt  = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_scnt_nxt  = r_scnt + SC_ONE;
          end
        end
      end
      S_STOP: begin
        if (r_tick) begin
          w_ferr_set = w_vote_pt & ~w_maj;
          // The last stop bit finishes at its vote point, leaving half a bit of resync margin.
          if (w_vote_pt && (r_bcnt == BC_LAST_STOP)) begin
            w_done      = 1'b1;
            w_scnt_nxt  = '0;
            w_bcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else if (w_bit_end) begin
            w_scnt_nxt  = '0;
            w_bcnt_nxt  = r_bcnt + BC_ONE;
          end else begin
            w_scnt_nxt  = r_scnt + SC_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sample and bit counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scnt <= '0;
      r_bcnt <= '0;
    end else begin
      r_scnt <= w_scnt_nxt;
      r_bcnt <= w_bcnt_nxt;
    end
  end

  // Vote samples around mid-bit, plus the previous tick's line level for edge qualification.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vote     <= '1;
      r_prev_rxs <= 1'b1;
    end else if (r_tick) begin
      r_prev_rxs <= w_rxs;
      if ((r_state != S_IDLE) &&
          ((r_scnt == SC_LO) || (r_scnt == SC_MID) || (r_scnt == SC_HI))) begin
        r_vote <= {r_vote[0], w_rxs};
      end
    end
  end

  // Payload shift register (LSB first), parity bit and frame-error accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_ferr_acc <= 1'b0;
    end else begin
      if (w_shift_en) begin
        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      end
      if (w_par_ld) begin
        r_par_bit <= w_maj;
      end
      if (w_ferr_clr) begin
        r_ferr_acc <= 1'b0;
      end else if (w_ferr_set) begin
        r_ferr_acc <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_busy;

  // Completion wins over acceptance so a same-clock accept/complete keeps valid high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_done) begin
      r_data_out   <= r_shift;
      r_parity_err <= w_par_err;
      r_frame_err  <= r_ferr_acc | ~w_maj;
      r_data_valid <= 1'b1;
      if (r_data_valid && !data_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_data_valid && data_ready) begin
      r_data_valid <= 1'b0;
    end
  end

  // Busy follows the FSM one clock late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE);
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule

// File: tb/tb_zrb_uart_rx_os.sv
// Directed testbench for zrb_uart_rx_os: an 8N1 instance and a 7E2 instance,
// both at 16x oversampling with a tick every 2 clocks (bit time 32 clocks).
module tb_zrb_uart_rx_os;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       rx8, rdy8, dv8, pe8, fe8, ov8, bz8;
  logic [7:0] d8;
  logic       rx7, rdy7, dv7, pe7, fe7, ov7, bz7;
  logic [6:0] d7;

  int n_total = 0;
  int n_pass  = 0;

  zrb_uart_rx_os #(
    .CLK_FREQ(3686400), .BAUD(115200), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_dut8 (
    .clk(clk), .reset_n(reset_n), .rx(rx8), .data_out(d8), .data_valid(dv8),
    .data_ready(rdy8), .parity_err(pe8), .frame_err(fe8), .overrun(ov8), .busy(bz8)
  );

  zrb_uart_rx_os #(
    .CLK_FREQ(3686400), .BAUD(115200), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u_dut7 (
    .clk(clk), .reset_n(reset_n), .rx(rx7), .data_out(d7), .data_valid(dv7),
    .data_ready(rdy7), .parity_err(pe7), .frame_err(fe7), .overrun(ov7), .busy(bz7)
  );

  // Free-running cycle counter and output monitors sampled on the falling edge.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned rise8 = 0, hi8 = 0, busy8_hi = 0, rise8_cyc = 0;
  logic        dv8_q = 1'b0;
  logic [7:0]  cap8 = '0;
  logic        cap8_pe = 1'b0, cap8_fe = 1'b0;

  int unsigned rise7 = 0;
  logic        dv7_q = 1'b0;
  logic [6:0]  cap7 = '0;
  logic        cap7_pe = 1'b0, cap7_fe = 1'b0;

  always @(negedge clk) begin
    dv8_q <= dv8;
    dv7_q <= dv7;
    if (dv8 && !dv8_q) begin
      rise8     <= rise8 + 1;
      rise8_cyc <= cyc;
      cap8      <= d8;
      cap8_pe   <= pe8;
      cap8_fe   <= fe8;
    end
    if (dv8) hi8 <= hi8 + 1;
    if (bz8) busy8_hi <= busy8_hi + 1;
    if (dv7 && !dv7_q) begin
      rise7   <= rise7 + 1;
      cap7    <= d7;
      cap7_pe <= pe7;
      cap7_fe <= fe7;
    end
  end

  int unsigned fall8_cyc = 0;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send8(input logic [7:0] b, input logic stop_v, input int bclk);
    logic [9:0] f;
    f = {stop_v, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx8 = f[i];
      if (i == 0) fall8_cyc = cyc;
      repeat (bclk) @(negedge clk);
    end
    rx8 = 1'b1;
  endtask

  task automatic send7(input logic [6:0] b, input logic par, input int bclk);
    logic [10:0] f;
    f = {2'b11, par, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rx7 = f[i];
      repeat (bclk) @(negedge clk);
    end
    rx7 = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx8 = 1'b1; rx7 = 1'b1; rdy8 = 1'b1; rdy7 = 1'b1;
    idle(3);
    n_total++; if (d8 !== 8'h00) $display("FAIL rst_data: got %0h exp 00", d8); else n_pass++;
    n_total++; if (dv8 !== 1'b0) $display("FAIL rst_valid: got %b exp 0", dv8); else n_pass++;
    n_total++; if (pe8 !== 1'b0 || fe8 !== 1'b0) $display("FAIL rst_flags: got pe=%b fe=%b exp 0 0", pe8, fe8); else n_pass++;
    n_total++; if (ov8 !== 1'b0) $display("FAIL rst_overrun: got %b exp 0", ov8); else n_pass++;
    n_total++; if (bz8 !== 1'b0) $display("FAIL rst_busy: got %b exp 0", bz8); else n_pass++;
    n_total++; if (d7 !== 7'h00 || dv7 !== 1'b0) $display("FAIL rst_dut7: got d=%0h v=%b exp 0 0", d7, dv7); else n_pass++;
    reset_n = 1'b1;
    idle(20);
  endtask

  task automatic test_8n1;
    int unsigned s_r, s_h, lat;
    s_r = rise8; s_h = hi8;
    send8(8'hA5, 1'b1, 32);
    idle(40);
    lat = rise8_cyc - fall8_cyc;
    n_total++; if (rise8 - s_r !== 1) $display("FAIL 8n1_rises: got %0d exp 1", rise8 - s_r); else n_pass++;
    n_total++; if (cap8 !== 8'hA5) $display("FAIL 8n1_data: got %0h exp a5", cap8); else n_pass++;
    n_total++; if (cap8_pe !== 1'b0 || cap8_fe !== 1'b0) $display("FAIL 8n1_flags: got pe=%b fe=%b exp 0 0", cap8_pe, cap8_fe); else n_pass++;
    n_total++; if (hi8 - s_h !== 1) $display("FAIL 8n1_valid_width: got %0d exp 1", hi8 - s_h); else n_pass++;
    n_total++; if (lat < 306 || lat > 312) $display("FAIL 8n1_latency: got %0d exp 306..312", lat); else n_pass++;
    n_total++; if (dv8 !== 1'b0 || bz8 !== 1'b0) $display("FAIL 8n1_idle: got v=%b busy=%b exp 0 0", dv8, bz8); else n_pass++;
  endtask

  task automatic test_7e2;
    int unsigned s_r;
    s_r = rise7;
    send7(7'h41, 1'b0, 32);
    idle(40);
    n_total++; if (rise7 - s_r !== 1) $display("FAIL 7e2_rises: got %0d exp 1", rise7 - s_r); else n_pass++;
    n_total++; if (cap7 !== 7'h41) $display("FAIL 7e2_data: got %0h exp 41", cap7); else n_pass++;
    n_total++; if (cap7_pe !== 1'b0 || cap7_fe !== 1'b0) $display("FAIL 7e2_flags: got pe=%b fe=%b exp 0 0", cap7_pe, cap7_fe); else n_pass++;
    send7(7'h41, 1'b1, 32);
    idle(40);
    n_total++; if (rise7 - s_r !== 2) $display("FAIL 7e2_badpar_rises: got %0d exp 2", rise7 - s_r); else n_pass++;
    n_total++; if (cap7 !== 7'h41) $display("FAIL 7e2_badpar_data: got %0h exp 41", cap7); else n_pass++;
    n_total++; if (cap7_pe !== 1'b1 || cap7_fe !== 1'b0) $display("FAIL 7e2_badpar_flags: got pe=%b fe=%b exp 1 0", cap7_pe, cap7_fe); else n_pass++;
  endtask

  task automatic test_glitch;
    int unsigned s_r, s_b;
    s_r = rise8; s_b = busy8_hi;
    @(negedge clk);
    rx8 = 1'b0;
    idle(6);
    rx8 = 1'b1;
    idle(400);
    n_total++; if (rise8 - s_r !== 0) $display("FAIL glitch_novalid: got %0d exp 0", rise8 - s_r); else n_pass++;
    n_total++; if (busy8_hi - s_b == 0) $display("FAIL glitch_busy_pulse: got %0d exp >0", busy8_hi - s_b); else n_pass++;
    n_total++; if (bz8 !== 1'b0) $display("FAIL glitch_busy_end: got %b exp 0", bz8); else n_pass++;
  endtask

  task automatic test_frame_err;
    int unsigned s_r;
    s_r = rise8;
    send8(8'h3C, 1'b0, 32);
    idle(32);
    n_total++; if (cap8 !== 8'h3C) $display("FAIL ferr_data: got %0h exp 3c", cap8); else n_pass++;
    n_total++; if (cap8_fe !== 1'b1) $display("FAIL ferr_flag: got %b exp 1", cap8_fe); else n_pass++;
    send8(8'h55, 1'b1, 32);
    idle(40);
    n_total++; if (rise8 - s_r !== 2) $display("FAIL ferr_rises: got %0d exp 2", rise8 - s_r); else n_pass++;
    n_total++; if (cap8 !== 8'h55) $display("FAIL ferr_next_data: got %0h exp 55", cap8); else n_pass++;
    n_total++; if (cap8_fe !== 1'b0) $display("FAIL ferr_next_flag: got %b exp 0", cap8_fe); else n_pass++;
  endtask

  task automatic test_back_to_back;
    rdy8 = 1'b0;
    send8(8'h11, 1'b1, 32);
    send8(8'h22, 1'b1, 32);
    idle(4);
    n_total++; if (ov8 !== 1'b1) $display("FAIL b2b_overrun: got %b exp 1", ov8); else n_pass++;
    n_total++; if (d8 !== 8'h22) $display("FAIL b2b_data: got %0h exp 22", d8); else n_pass++;
    n_total++; if (dv8 !== 1'b1) $display("FAIL b2b_valid_held: got %b exp 1", dv8); else n_pass++;
    rdy8 = 1'b1;
    @(negedge clk);
    rdy8 = 1'b0;
    @(negedge clk);
    n_total++; if (dv8 !== 1'b0) $display("FAIL b2b_accept: got %b exp 0", dv8); else n_pass++;
    n_total++; if (ov8 !== 1'b1) $display("FAIL b2b_overrun_after_accept: got %b exp 1", ov8); else n_pass++;
    idle(100);
    n_total++; if (ov8 !== 1'b1) $display("FAIL b2b_overrun_sticky: got %b exp 1", ov8); else n_pass++;
    rdy8 = 1'b1;
  endtask

  task automatic test_reset_midframe;
    int unsigned s_r;
    s_r = rise8;
    fork
      send8(8'hFF, 1'b1, 32);
      begin
        repeat (5 * 32 + 17) @(negedge clk);
        n_total++; if (bz8 !== 1'b1) $display("FAIL mid_busy_before: got %b exp 1", bz8); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (bz8 !== 1'b0) $display("FAIL mid_busy_reset: got %b exp 0", bz8); else n_pass++;
        n_total++; if (ov8 !== 1'b0) $display("FAIL mid_overrun_reset: got %b exp 0", ov8); else n_pass++;
        n_total++; if (d8 !== 8'h00 || dv8 !== 1'b0) $display("FAIL mid_data_reset: got d=%0h v=%b exp 0 0", d8, dv8); else n_pass++;
        repeat (8) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    idle(64);
    n_total++; if (rise8 - s_r !== 0) $display("FAIL mid_no_valid: got %0d exp 0", rise8 - s_r); else n_pass++;
    send8(8'h5A, 1'b1, 32);
    idle(40);
    n_total++; if (rise8 - s_r !== 1) $display("FAIL mid_after_rises: got %0d exp 1", rise8 - s_r); else n_pass++;
    n_total++; if (cap8 !== 8'h5A) $display("FAIL mid_after_data: got %0h exp 5a", cap8); else n_pass++;
    n_total++; if (cap8_fe !== 1'b0 || cap8_pe !== 1'b0) $display("FAIL mid_after_flags: got pe=%b fe=%b exp 0 0", cap8_pe, cap8_fe); else n_pass++;
  endtask

  task automatic test_baud_error;
    int unsigned s_r;
    s_r = rise8;
    send8(8'h5A, 1'b1, 33);
    idle(40);
    n_total++; if (cap8 !== 8'h5A || rise8 - s_r !== 1) $display("FAIL baud_slow: got %0h/%0d exp 5a/1", cap8, rise8 - s_r); else n_pass++;
    n_total++; if (cap8_fe !== 1'b0) $display("FAIL baud_slow_ferr: got %b exp 0", cap8_fe); else n_pass++;
    send8(8'h5A, 1'b1, 31);
    idle(40);
    n_total++; if (cap8 !== 8'h5A || rise8 - s_r !== 2) $display("FAIL baud_fast: got %0h/%0d exp 5a/2", cap8, rise8 - s_r); else n_pass++;
    n_total++; if (cap8_fe !== 1'b0) $display("FAIL baud_fast_ferr: got %b exp 0", cap8_fe); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_baud_error();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
